// File: rtl/isp_stream_monitor_if.sv
// Beat-level pixel stream bundle tapped by the ISP stream monitor.
// Colour codes live here so the monitor and its users share one encoding.
`ifndef COLOR_BIT_CNT
`define COLOR_BIT_CNT 2
`endif
`ifndef RED
`define RED   (`COLOR_BIT_CNT'(0))
`endif
`ifndef GREEN
`define GREEN (`COLOR_BIT_CNT'(1))
`endif
`ifndef BLUE
`define BLUE  (`COLOR_BIT_CNT'(2))
`endif
`ifndef VOID
`define VOID  (`COLOR_BIT_CNT'(3))
`endif

interface isp_stream_monitor_if #(
  parameter int COLOR_DEPTH = 8
);
  logic [COLOR_DEPTH-1:0]    pixel_in;
  logic                      valid_in;
  logic [`COLOR_BIT_CNT-1:0] color_in;
  logic                      last_col_in;
  logic                      last_pic_in;

  modport master (output pixel_in, valid_in, color_in, last_col_in, last_pic_in);
  modport slave  (input  pixel_in, valid_in, color_in, last_col_in, last_pic_in);
endinterface

// File: rtl/isp_stream_monitor.sv
// Passive checker for one ISP stage boundary: framing, colour order, watchdog,
// per-channel frame means and a frame countdown to finish_operation.
module isp_stream_monitor #(
  parameter int COLOR_DEPTH = 8,
  parameter int IMG_COL     = 1024,
  parameter int IMG_ROW     = 1024,
  parameter int NUM_CH      = 3,
  parameter int FRAMES      = 1,
  parameter int TIMEOUT     = 4096,
  parameter int ERR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  isp_stream_monitor_if.slave    s,
  input  logic                   clear_in,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   col_err,
  output logic                   pic_err,
  output logic                   color_err,
  output logic                   timeout_err,
  output logic [COLOR_DEPTH-1:0] mean_r,
  output logic [COLOR_DEPTH-1:0] mean_g,
  output logic [COLOR_DEPTH-1:0] mean_b,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt,
  output logic                   finish_operation
);
  localparam int SH     = $clog2(IMG_COL * IMG_ROW);
  localparam int SUM_W  = COLOR_DEPTH + SH;
  localparam int BEAT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int COL_W  = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int ROW_W  = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(NUM_CH - 1);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(IMG_ROW - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT - 1);
  localparam logic [7:0]        FRAMES_LAST = 8'(FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_reg, state_next;

  logic [BEAT_W-1:0]      beat_reg, beat_next;
  logic [COL_W-1:0]       col_reg, col_next;
  logic [ROW_W-1:0]       row_reg, row_next;
  logic [IDLE_W-1:0]      idle_reg, idle_next;
  logic [SUM_W-1:0]       sum_r_reg, sum_r_next, sum_g_reg, sum_g_next, sum_b_reg, sum_b_next;
  logic [SUM_W-1:0]       sum_r_add, sum_g_add, sum_b_add;
  logic [ERR_W-1:0]       err_reg, err_next;
  logic                   col_err_reg, col_err_next, pic_err_reg, pic_err_next;
  logic                   color_err_reg, color_err_next, timeout_err_reg, timeout_err_next;
  logic [COLOR_DEPTH-1:0] mean_r_reg, mean_r_next, mean_g_reg, mean_g_next, mean_b_reg, mean_b_next;
  logic                   done_reg, done_next, finish_reg, finish_next;
  logic [7:0]             frame_cnt_reg, frame_cnt_next;

  logic                      beat_fire, exp_last_col, exp_last_pic, frame_end, timeout_hit;
  logic                      color_bad, col_bad, pic_bad;
  logic [`COLOR_BIT_CNT-1:0] exp_color;
  logic [2:0]                err_inc;
  logic [ERR_W:0]            err_sum;

  always_comb begin
    beat_fire    = s.valid_in && (state_reg != DONE);
    exp_last_col = (beat_reg == BEAT_LAST) && (col_reg == COL_LAST);
    exp_last_pic = exp_last_col && (row_reg == ROW_LAST);
    if (NUM_CH == 1)                 exp_color = `VOID;
    else if (beat_reg == '0)         exp_color = `RED;
    else if (beat_reg == BEAT_W'(1)) exp_color = `GREEN;
    else                             exp_color = `BLUE;

    color_bad   = beat_fire && (s.color_in != exp_color);
    col_bad     = beat_fire && (s.last_col_in != exp_last_col);
    pic_bad     = beat_fire && (s.last_pic_in != exp_last_pic);
    frame_end   = beat_fire && (exp_last_pic || s.last_pic_in);
    timeout_hit = (state_reg == ACTIVE) && !s.valid_in && (idle_reg == IDLE_LAST);

    err_inc = {2'b00, color_bad} + {2'b00, col_bad} + {2'b00, pic_bad} + {2'b00, timeout_hit};
    err_sum = {1'b0, err_reg} + (ERR_W + 1)'(err_inc);
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    // Channel routing follows the expected beat slot, not the claimed colour.
    sum_r_add = sum_r_reg;
    sum_g_add = sum_g_reg;
    sum_b_add = sum_b_reg;
    if (beat_fire) begin
      if (NUM_CH == 1 || beat_reg == '0) sum_r_add = sum_r_reg + SUM_W'(s.pixel_in);
      else if (beat_reg == BEAT_W'(1))   sum_g_add = sum_g_reg + SUM_W'(s.pixel_in);
      else                               sum_b_add = sum_b_reg + SUM_W'(s.pixel_in);
    end

    state_next       = state_reg;
    beat_next        = beat_reg;
    col_next         = col_reg;
    row_next         = row_reg;
    idle_next        = idle_reg;
    sum_r_next       = sum_r_add;
    sum_g_next       = sum_g_add;
    sum_b_next       = sum_b_add;
    col_err_next     = col_err_reg | col_bad;
    pic_err_next     = pic_err_reg | pic_bad;
    color_err_next   = color_err_reg | color_bad;
    timeout_err_next = timeout_err_reg | timeout_hit;
    mean_r_next      = mean_r_reg;
    mean_g_next      = mean_g_reg;
    mean_b_next      = mean_b_reg;
    done_next        = 1'b0;
    frame_cnt_next   = frame_cnt_reg;
    finish_next      = finish_reg;

    if (beat_fire) begin
      idle_next = '0;
      if (state_reg == IDLE) state_next = ACTIVE;
      if (beat_reg == BEAT_LAST) begin
        beat_next = '0;
        if (col_reg == COL_LAST) begin
          col_next = '0;
          row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end else begin
        beat_next = beat_reg + 1'b1;
      end
    end else if (state_reg == ACTIVE) begin
      idle_next = idle_reg + 1'b1;
    end

    // Truncated frames are still normalised by the full-frame pixel count.
    if (frame_end) begin
      beat_next      = '0;
      col_next       = '0;
      row_next       = '0;
      sum_r_next     = '0;
      sum_g_next     = '0;
      sum_b_next     = '0;
      mean_r_next    = sum_r_add[SUM_W-1:SH];
      mean_g_next    = sum_g_add[SUM_W-1:SH];
      mean_b_next    = sum_b_add[SUM_W-1:SH];
      done_next      = 1'b1;
      frame_cnt_next = frame_cnt_reg + 8'd1;
      if (frame_cnt_reg == FRAMES_LAST) begin
        finish_next = 1'b1;
        state_next  = DONE;
      end else begin
        state_next  = IDLE;
      end
    end

    if (timeout_hit) begin
      state_next = IDLE;
      beat_next  = '0;
      col_next   = '0;
      row_next   = '0;
      idle_next  = '0;
      sum_r_next = '0;
      sum_g_next = '0;
      sum_b_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear_in) begin
      state_reg       <= IDLE;
      beat_reg        <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      idle_reg        <= '0;
      sum_r_reg       <= '0;
      sum_g_reg       <= '0;
      sum_b_reg       <= '0;
      err_reg         <= '0;
      col_err_reg     <= 1'b0;
      pic_err_reg     <= 1'b0;
      color_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      mean_r_reg      <= '0;
      mean_g_reg      <= '0;
      mean_b_reg      <= '0;
      done_reg        <= 1'b0;
      frame_cnt_reg   <= '0;
      finish_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      beat_reg        <= beat_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      idle_reg        <= idle_next;
      sum_r_reg       <= sum_r_next;
      sum_g_reg       <= sum_g_next;
      sum_b_reg       <= sum_b_next;
      err_reg         <= err_next;
      col_err_reg     <= col_err_next;
      pic_err_reg     <= pic_err_next;
      color_err_reg   <= color_err_next;
      timeout_err_reg <= timeout_err_next;
      mean_r_reg      <= mean_r_next;
      mean_g_reg      <= mean_g_next;
      mean_b_reg      <= mean_b_next;
      done_reg        <= done_next;
      frame_cnt_reg   <= frame_cnt_next;
      finish_reg      <= finish_next;
    end
  end

  assign err_cnt          = err_reg;
  assign col_err          = col_err_reg;
  assign pic_err          = pic_err_reg;
  assign color_err        = color_err_reg;
  assign timeout_err      = timeout_err_reg;
  assign mean_r           = mean_r_reg;
  assign mean_g           = mean_g_reg;
  assign mean_b           = mean_b_reg;
  assign frame_done       = done_reg;
  assign frame_cnt        = frame_cnt_reg;
  assign finish_operation = finish_reg;
endmodule

// File: tb/tb_isp_stream_monitor.sv
// Directed bench for isp_stream_monitor on a 4x2 RGB image, one frame to finish.
module tb_isp_stream_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_in = 1'b0;
  always #5 clk = ~clk;

  isp_stream_monitor_if #(.COLOR_DEPTH(8)) bus ();

  logic [15:0] err_cnt;
  logic        col_err, pic_err, color_err, timeout_err;
  logic [7:0]  mean_r, mean_g, mean_b;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        finish_operation;

  isp_stream_monitor #(
    .COLOR_DEPTH(8), .IMG_COL(4), .IMG_ROW(2), .NUM_CH(3),
    .FRAMES(1), .TIMEOUT(8), .ERR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(bus), .clear_in(clear_in),
    .err_cnt(err_cnt), .col_err(col_err), .pic_err(pic_err),
    .color_err(color_err), .timeout_err(timeout_err),
    .mean_r(mean_r), .mean_g(mean_g), .mean_b(mean_b),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .finish_operation(finish_operation)
  );

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  int done_base;

  always @(posedge clk) if (frame_done) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic beat(input logic [7:0] p, input logic [1:0] c, input logic lc, input logic lp);
    bus.valid_in = 1'b1;
    bus.pixel_in = p;
    bus.color_in = c;
    bus.last_col_in = lc;
    bus.last_pic_in = lp;
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.last_col_in = 1'b0;
    bus.last_pic_in = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] r, g, b, input logic lc, input logic lp);
    beat(r, `RED, 1'b0, 1'b0);
    beat(g, `GREEN, 1'b0, 1'b0);
    beat(b, `BLUE, lc, lp);
  endtask

  task automatic gap(input int n);
    bus.valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] r, g, b, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      pixel(r, g, b, (i % 4) == 3, i == 7);
      if (i != last) gap(1);
    end
  endtask

  // The beat presented alongside clear carries every flag and a bad colour.
  task automatic do_clear();
    bus.valid_in = 1'b1;
    bus.pixel_in = 8'hFF;
    bus.color_in = `VOID;
    bus.last_col_in = 1'b1;
    bus.last_pic_in = 1'b1;
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.last_col_in = 1'b0;
    bus.last_pic_in = 1'b0;
    gap(1);
    done_base = done_seen;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.pixel_in = '0;
    bus.color_in = `VOID;
    bus.last_col_in = 1'b0;
    bus.last_pic_in = 1'b0;
    gap(2);
    check("reset err_cnt", err_cnt, 0);
    check("reset frame_cnt", frame_cnt, 0);
    check("reset finish", finish_operation, 0);
    rst_n = 1'b1;
    gap(1);
    done_base = done_seen;

    // 1: clean frame
    frame(8'd10, 8'd20, 8'd30, 0, 7);
    check("t1 frame_done pulse", frame_done, 1);
    check("t1 err_cnt", err_cnt, 0);
    check("t1 mean_r", mean_r, 10);
    check("t1 mean_g", mean_g, 20);
    check("t1 mean_b", mean_b, 30);
    check("t1 frame_cnt", frame_cnt, 1);
    check("t1 finish", finish_operation, 1);
    gap(1);
    check("t1 frame_done low", frame_done, 0);
    beat(8'd99, `BLUE, 1'b1, 1'b1);
    gap(1);
    check("t1 done holds err", err_cnt, 0);
    check("t1 done holds mean_r", mean_r, 10);
    check("t1 done pulses", done_seen - done_base, 1);

    // Clear with a simultaneous bad beat: clear wins
    do_clear();
    check("clr err_cnt", err_cnt, 0);
    check("clr frame_cnt", frame_cnt, 0);
    check("clr finish", finish_operation, 0);

    // 2: last_col dropped on pixel 3
    for (int i = 0; i < 8; i++) begin
      pixel(8'd10, 8'd20, 8'd30, i == 7, i == 7);
      gap(1);
    end
    check("t2 err_cnt", err_cnt, 1);
    check("t2 col_err", col_err, 1);
    check("t2 pic_err", pic_err, 0);
    check("t2 color_err", color_err, 0);
    check("t2 finish", finish_operation, 1);

    // 3: pixel 0 as R,B,G
    do_clear();
    beat(8'd10, `RED, 1'b0, 1'b0);
    beat(8'd20, `BLUE, 1'b0, 1'b0);
    beat(8'd30, `GREEN, 1'b0, 1'b0);
    gap(1);
    frame(8'd10, 8'd20, 8'd30, 1, 7);
    check("t3 err_cnt", err_cnt, 2);
    check("t3 color_err", color_err, 1);
    check("t3 col_err", col_err, 0);
    check("t3 mean_g", mean_g, 20);

    // 4: early last_pic on pixel 5
    do_clear();
    for (int i = 0; i < 6; i++) begin
      pixel(8'd4, 8'd6, 8'd8, i == 3, i == 5);
      if (i != 5) gap(1);
    end
    check("t4 frame_done", frame_done, 1);
    check("t4 pic_err", pic_err, 1);
    check("t4 col_err", col_err, 0);
    check("t4 err_cnt", err_cnt, 1);
    check("t4 mean_b", mean_b, 6);
    check("t4 mean_g", mean_g, 4);
    check("t4 mean_r", mean_r, 3);
    check("t4 finish", finish_operation, 1);

    // 5: watchdog after pixel 2
    do_clear();
    frame(8'd10, 8'd20, 8'd30, 0, 2);
    gap(7);
    check("t5 no timeout at 7", timeout_err, 0);
    gap(1);
    check("t5 timeout_err", timeout_err, 1);
    check("t5 err_cnt", err_cnt, 1);
    check("t5 no frame_done", done_seen - done_base, 0);
    check("t5 finish low", finish_operation, 0);
    frame(8'd10, 8'd20, 8'd30, 0, 7);
    check("t5 finish", finish_operation, 1);
    check("t5 mean_g", mean_g, 20);
    check("t5 err_cnt after", err_cnt, 1);

    // 6: async reset mid pixel 4
    do_clear();
    for (int i = 0; i < 4; i++) begin
      pixel(8'd10, 8'd20, 8'd30, (i == 1) || (i == 3), 1'b0);
      gap(1);
    end
    beat(8'd10, `RED, 1'b0, 1'b0);
    check("t6 pre-reset err_cnt", err_cnt, 1);
    bus.valid_in = 1'b1;
    bus.color_in = `GREEN;
    rst_n = 1'b0;
    #1;
    check("t6 reset err_cnt", err_cnt, 0);
    check("t6 reset col_err", col_err, 0);
    check("t6 reset frame_cnt", frame_cnt, 0);
    bus.valid_in = 1'b0;
    gap(2);
    rst_n = 1'b1;
    gap(1);
    frame(8'd10, 8'd20, 8'd30, 0, 7);
    check("t6 err_cnt", err_cnt, 0);
    check("t6 mean_r", mean_r, 10);
    check("t6 mean_b", mean_b, 30);
    check("t6 finish", finish_operation, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
